uart_reg_bridge: RTL and testbench

UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bridge_timer.sv | 28 ++
 rtl/uart_reg_bridge.sv | 151 +++++++++++++++
 tb/tb_uart_reg_bridge.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared command/response codes and FSM state encoding for the UART register bridge.
package uart_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_UNK = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS,
    ST_RESP0,
    ST_RESP1
  } state_t;

endpackage

// File: rtl/uart_bridge_timer.sv
// Bus acknowledge timeout counter: cleared outside BUS, counts cycles waiting for ack.
module uart_bridge_timer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int WIDTH_TO    = 5
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [WIDTH_TO-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Asserted in the cycle whose increment brings the count to ACK_TIMEOUT.
  assign done = en && (cnt == WIDTH_TO'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/uart_reg_bridge.sv
// Byte-command UART to register-bus bridge: 'W' addr data / 'R' addr, answered with K/E/?.
module uart_reg_bridge
  import uart_pkg::*;
#(
  parameter int WIDTH_DATA  = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int WIDTH_TO    = 5
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [WIDTH_DATA-1:0] i_rx_data,
  input  logic                  i_rx_rdy,
  output logic                  o_rx_re,
  output logic [WIDTH_DATA-1:0] o_tx_data,
  output logic                  o_tx_we,
  input  logic                  i_tx_mty,
  output logic [WIDTH_DATA-1:0] o_bus_addr,
  output logic [WIDTH_DATA-1:0] o_bus_wdata,
  output logic                  o_bus_we,
  output logic                  o_bus_re,
  input  logic [WIDTH_DATA-1:0] i_bus_rdata,
  input  logic                  i_bus_ack
);

  state_t                state;
  logic                  cmd_is_wr;
  logic [WIDTH_DATA-1:0] addr_q;
  logic [WIDTH_DATA-1:0] wdata_q;
  logic [WIDTH_DATA-1:0] rdata_q;
  logic [WIDTH_DATA-1:0] resp_q;
  logic                  rd_ok;
  logic                  rx_hold;
  logic                  tx_hold;
  logic                  tmr_done;
  logic                  rx_take;
  logic                  tx_take;

  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;

  // Each pulse is followed by one blind cycle so the peer can retire its flag.
  assign rx_take = i_rx_rdy && !rx_hold;
  assign tx_take = i_tx_mty && !tx_hold;

  uart_bridge_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .WIDTH_TO   (WIDTH_TO)
  ) u_timer (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .clr   (state != ST_BUS),
    .en    ((state == ST_BUS) && !i_bus_ack),
    .done  (tmr_done)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= ST_IDLE;
      cmd_is_wr <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      rd_ok     <= 1'b0;
      rx_hold   <= 1'b0;
      tx_hold   <= 1'b0;
      o_rx_re   <= 1'b0;
      o_tx_data <= '0;
      o_tx_we   <= 1'b0;
      o_bus_we  <= 1'b0;
      o_bus_re  <= 1'b0;
    end else begin
      o_rx_re <= 1'b0;
      o_tx_we <= 1'b0;
      rx_hold <= 1'b0;
      tx_hold <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_take) begin
            o_rx_re <= 1'b1;
            rx_hold <= 1'b1;
            if (i_rx_data == WIDTH_DATA'(CMD_WR) || i_rx_data == WIDTH_DATA'(CMD_RD)) begin
              cmd_is_wr <= (i_rx_data == WIDTH_DATA'(CMD_WR));
              state     <= ST_GET_ADDR;
            end else begin
              resp_q <= WIDTH_DATA'(RSP_UNK);
              rd_ok  <= 1'b0;
              state  <= ST_RESP0;
            end
          end
        end
        ST_GET_ADDR: begin
          if (rx_take) begin
            o_rx_re <= 1'b1;
            rx_hold <= 1'b1;
            addr_q  <= i_rx_data;
            if (cmd_is_wr) begin
              state <= ST_GET_DATA;
            end else begin
              o_bus_re <= 1'b1;
              state    <= ST_BUS;
            end
          end
        end
        ST_GET_DATA: begin
          if (rx_take) begin
            o_rx_re  <= 1'b1;
            rx_hold  <= 1'b1;
            wdata_q  <= i_rx_data;
            o_bus_we <= 1'b1;
            state    <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (i_bus_ack) begin
            o_bus_we <= 1'b0;
            o_bus_re <= 1'b0;
            resp_q   <= WIDTH_DATA'(RSP_OK);
            rd_ok    <= !cmd_is_wr;
            if (!cmd_is_wr) rdata_q <= i_bus_rdata;
            state    <= ST_RESP0;
          end else if (tmr_done) begin
            o_bus_we <= 1'b0;
            o_bus_re <= 1'b0;
            resp_q   <= WIDTH_DATA'(RSP_ERR);
            rd_ok    <= 1'b0;
            state    <= ST_RESP0;
          end
        end
        ST_RESP0: begin
          if (tx_take) begin
            o_tx_data <= resp_q;
            o_tx_we   <= 1'b1;
            tx_hold   <= 1'b1;
            state     <= rd_ok ? ST_RESP1 : ST_IDLE;
          end
        end
        ST_RESP1: begin
          if (tx_take) begin
            o_tx_data <= rdata_q;
            o_tx_we   <= 1'b1;
            tx_hold   <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge with UART rx/tx and register-target models.
module tb_uart_reg_bridge;

  logic       i_clk = 1'b0;
  logic       i_nrst;
  logic [7:0] i_rx_data;
  logic       i_rx_rdy;
  logic       o_rx_re;
  logic [7:0] o_tx_data;
  logic       o_tx_we;
  logic       i_tx_mty;
  logic [7:0] o_bus_addr;
  logic [7:0] o_bus_wdata;
  logic       o_bus_we;
  logic       o_bus_re;
  logic [7:0] i_bus_rdata;
  logic       i_bus_ack;

  int n_cmp = 0;
  int n_bad = 0;

  // Written only by the stimulus process.
  logic [7:0] rx_buf [256];
  int         rx_wr = 0;
  int         tx_rd = 0;
  bit         tx_block = 1'b0;
  bit         ack_en = 1'b1;
  int         ack_delay = 0;
  logic [7:0] rd_val = 8'h00;
  logic [7:0] exp_q [$];

  // Written only by the model process.
  int         rx_rd = 0;
  logic [7:0] tx_log [256];
  int         tx_cnt = 0;
  int         tx_busy = 0;
  int         bus_cyc = 0;
  int         we_tot = 0;
  int         re_tot = 0;
  int         both_tot = 0;
  int         unstable = 0;
  int         rx_in_bus = 0;
  bit         prev_strobe = 1'b0;
  logic [7:0] a0 = 8'h00;
  logic [7:0] d0 = 8'h00;

  always #5 i_clk = ~i_clk;

  uart_reg_bridge #(
    .WIDTH_DATA (8),
    .ACK_TIMEOUT(16),
    .WIDTH_TO   (5)
  ) dut (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_rx_data  (i_rx_data),
    .i_rx_rdy   (i_rx_rdy),
    .o_rx_re    (o_rx_re),
    .o_tx_data  (o_tx_data),
    .o_tx_we    (o_tx_we),
    .i_tx_mty   (i_tx_mty),
    .o_bus_addr (o_bus_addr),
    .o_bus_wdata(o_bus_wdata),
    .o_bus_we   (o_bus_we),
    .o_bus_re   (o_bus_re),
    .i_bus_rdata(i_bus_rdata),
    .i_bus_ack  (i_bus_ack)
  );

  // UART receiver, UART transmitter and register target, all updated on the falling edge.
  initial begin
    i_rx_rdy    = 1'b0;
    i_rx_data   = 8'h00;
    i_tx_mty    = 1'b1;
    i_bus_ack   = 1'b0;
    i_bus_rdata = 8'h00;
    forever begin
      @(negedge i_clk);
      if (o_rx_re) begin
        if (prev_strobe) rx_in_bus++;
        rx_rd++;
      end
      i_rx_rdy  = (rx_rd < rx_wr);
      i_rx_data = (rx_rd < rx_wr) ? rx_buf[rx_rd] : 8'h00;

      if (o_tx_we) begin
        tx_log[tx_cnt] = o_tx_data;
        tx_cnt++;
        tx_busy = 3;
      end else if (tx_busy > 0) begin
        tx_busy--;
      end
      i_tx_mty = !tx_block && (tx_busy == 0);

      if (o_bus_we || o_bus_re) begin
        bus_cyc++;
        if (o_bus_we) we_tot++;
        if (o_bus_re) re_tot++;
        if (o_bus_we && o_bus_re) both_tot++;
        if (bus_cyc == 1) begin
          a0 = o_bus_addr;
          d0 = o_bus_wdata;
        end else if (o_bus_addr !== a0 || o_bus_wdata !== d0) begin
          unstable++;
        end
        i_bus_ack   = ack_en && (bus_cyc == ack_delay + 1);
        i_bus_rdata = i_bus_ack ? rd_val : 8'h00;
      end else begin
        bus_cyc     = 0;
        i_bus_ack   = 1'b0;
        i_bus_rdata = 8'h00;
      end
      prev_strobe = o_bus_we || o_bus_re;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_rx(input logic [7:0] b);
    rx_buf[rx_wr] = b;
    rx_wr++;
  endtask

  task automatic wait_tx(input int n, output bit ok);
    int k = 0;
    while ((tx_cnt - tx_rd) < n && k < 400) begin
      @(negedge i_clk);
      k++;
    end
    ok = ((tx_cnt - tx_rd) >= n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic test_reset;
    logic [27:0] outs;
    idle(3);
    outs = {o_rx_re, o_tx_data, o_tx_we, o_bus_addr, o_bus_wdata, o_bus_we, o_bus_re};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    i_nrst = 1'b1;
    idle(2);
  endtask

  task automatic test_write;
    int we0 = we_tot, re0 = re_tot, un0 = unstable;
    bit ok;
    logic [7:0] e, g;
    ack_en = 1'b1; ack_delay = 2;
    push_rx(8'h57); push_rx(8'h10); push_rx(8'hA5);
    exp_q.push_back(8'h4B);
    wait_tx(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL write_wait got=%0d exp=%0d", tx_cnt - tx_rd, exp_q.size()); end
    while (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = tx_log[tx_rd]; tx_rd++;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL write_tx got=%h exp=%h", g, e); end
    end
    exp_q.delete();
    idle(10);
    n_cmp++;
    if (tx_cnt != tx_rd) begin n_bad++; $display("FAIL write_extra_tx got=%0d exp=0", tx_cnt - tx_rd); tx_rd = tx_cnt; end
    n_cmp++;
    if (we_tot - we0 != 3) begin n_bad++; $display("FAIL write_we_cycles got=%0d exp=3", we_tot - we0); end
    n_cmp++;
    if (re_tot != re0) begin n_bad++; $display("FAIL write_re_cycles got=%0d exp=0", re_tot - re0); end
    n_cmp++;
    if (a0 !== 8'h10 || d0 !== 8'hA5) begin n_bad++; $display("FAIL write_bus_fields got=%h/%h exp=10/a5", a0, d0); end
    n_cmp++;
    if (unstable != un0) begin n_bad++; $display("FAIL write_stable got=%0d exp=0", unstable - un0); end
  endtask

  task automatic test_read;
    int we0 = we_tot, re0 = re_tot;
    bit ok;
    logic [7:0] e, g;
    ack_en = 1'b1; ack_delay = 1; rd_val = 8'h3C;
    push_rx(8'h52); push_rx(8'h22);
    exp_q.push_back(8'h4B); exp_q.push_back(8'h3C);
    wait_tx(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL read_wait got=%0d exp=%0d", tx_cnt - tx_rd, exp_q.size()); end
    while (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = tx_log[tx_rd]; tx_rd++;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL read_tx got=%h exp=%h", g, e); end
    end
    exp_q.delete();
    idle(10);
    n_cmp++;
    if (tx_cnt != tx_rd) begin n_bad++; $display("FAIL read_extra_tx got=%0d exp=0", tx_cnt - tx_rd); tx_rd = tx_cnt; end
    n_cmp++;
    if (we_tot != we0) begin n_bad++; $display("FAIL read_we_cycles got=%0d exp=0", we_tot - we0); end
    n_cmp++;
    if (re_tot - re0 != 2) begin n_bad++; $display("FAIL read_re_cycles got=%0d exp=2", re_tot - re0); end
    n_cmp++;
    if (a0 !== 8'h22) begin n_bad++; $display("FAIL read_addr got=%h exp=22", a0); end
  endtask

  task automatic test_timeout;
    int re0 = re_tot;
    bit ok;
    logic [7:0] e, g;
    ack_en = 1'b0;
    push_rx(8'h52); push_rx(8'h05);
    exp_q.push_back(8'h45);
    wait_tx(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL timeout_wait got=%0d exp=%0d", tx_cnt - tx_rd, exp_q.size()); end
    while (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = tx_log[tx_rd]; tx_rd++;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL timeout_tx got=%h exp=%h", g, e); end
    end
    exp_q.delete();
    idle(10);
    n_cmp++;
    if (tx_cnt != tx_rd) begin n_bad++; $display("FAIL timeout_extra_tx got=%0d exp=0", tx_cnt - tx_rd); tx_rd = tx_cnt; end
    n_cmp++;
    if (re_tot - re0 != 16) begin n_bad++; $display("FAIL timeout_re_cycles got=%0d exp=16", re_tot - re0); end
    ack_en = 1'b1;
  endtask

  task automatic test_unknown;
    int we0 = we_tot, re0 = re_tot;
    bit ok;
    logic [7:0] e, g;
    ack_delay = 0;
    push_rx(8'h00);
    exp_q.push_back(8'h3F);
    wait_tx(exp_q.size(), ok);
    idle(5);
    n_cmp++;
    if (we_tot != we0 || re_tot != re0) begin n_bad++; $display("FAIL unknown_strobe got=%0d exp=0", we_tot - we0 + re_tot - re0); end
    push_rx(8'h57); push_rx(8'h30); push_rx(8'h5A);
    exp_q.push_back(8'h4B);
    wait_tx(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL unknown_wait got=%0d exp=%0d", tx_cnt - tx_rd, exp_q.size()); end
    while (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = tx_log[tx_rd]; tx_rd++;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL unknown_tx got=%h exp=%h", g, e); end
    end
    exp_q.delete();
    idle(10);
    tx_rd = tx_cnt;
    n_cmp++;
    if (we_tot - we0 != 1 || a0 !== 8'h30 || d0 !== 8'h5A) begin
      n_bad++;
      $display("FAIL unknown_then_write got=%0d/%h/%h exp=1/30/5a", we_tot - we0, a0, d0);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [7:0] e, g;
    tx_block = 1'b1;
    ack_delay = 0; rd_val = 8'h99;
    push_rx(8'h52); push_rx(8'h44);
    exp_q.push_back(8'h4B); exp_q.push_back(8'h99);
    idle(50);
    n_cmp++;
    if (tx_cnt != tx_rd) begin n_bad++; $display("FAIL bp_early_tx got=%0d exp=0", tx_cnt - tx_rd); end
    tx_block = 1'b0;
    wait_tx(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_wait got=%0d exp=%0d", tx_cnt - tx_rd, exp_q.size()); end
    while (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = tx_log[tx_rd]; tx_rd++;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL bp_tx got=%h exp=%h", g, e); end
    end
    exp_q.delete();
    idle(10);
    n_cmp++;
    if (tx_cnt != tx_rd) begin n_bad++; $display("FAIL bp_duplicate got=%0d exp=0", tx_cnt - tx_rd); tx_rd = tx_cnt; end
  endtask

  task automatic test_reset_mid;
    int we0, re0, tx0, k = 0;
    logic [27:0] outs;
    bit ok;
    logic [7:0] e, g;
    push_rx(8'h57); push_rx(8'h10);
    while (rx_rd < rx_wr && k < 100) begin @(negedge i_clk); k++; end
    idle(2);
    we0 = we_tot; re0 = re_tot; tx0 = tx_cnt;
    i_nrst = 1'b0;
    idle(3);
    outs = {o_rx_re, o_tx_data, o_tx_we, o_bus_addr, o_bus_wdata, o_bus_we, o_bus_re};
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL midreset_outputs got=%h exp=0", outs); end
    i_nrst = 1'b1;
    idle(30);
    n_cmp++;
    if (we_tot != we0 || re_tot != re0 || tx_cnt != tx0) begin
      n_bad++;
      $display("FAIL midreset_aborted got=%0d/%0d/%0d exp=0/0/0", we_tot - we0, re_tot - re0, tx_cnt - tx0);
      tx_rd = tx_cnt;
    end
    push_rx(8'h57); push_rx(8'h11); push_rx(8'h22);
    exp_q.push_back(8'h4B);
    wait_tx(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL midreset_wait got=%0d exp=%0d", tx_cnt - tx_rd, exp_q.size()); end
    while (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = tx_log[tx_rd]; tx_rd++;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL midreset_tx got=%h exp=%h", g, e); end
    end
    exp_q.delete();
    idle(10);
    tx_rd = tx_cnt;
    n_cmp++;
    if (a0 !== 8'h11 || d0 !== 8'h22) begin n_bad++; $display("FAIL midreset_next got=%h/%h exp=11/22", a0, d0); end
  endtask

  task automatic test_back_to_back;
    int rib0 = rx_in_bus, both0 = both_tot, un0 = unstable;
    bit ok;
    logic [7:0] e, g;
    ack_en = 1'b1; ack_delay = 0; rd_val = 8'h77;
    push_rx(8'h57); push_rx(8'h01); push_rx(8'h11);
    exp_q.push_back(8'h4B);
    push_rx(8'h52); push_rx(8'h02);
    exp_q.push_back(8'h4B); exp_q.push_back(8'h77);
    push_rx(8'h99);
    exp_q.push_back(8'h3F);
    push_rx(8'h57); push_rx(8'h03); push_rx(8'h33);
    exp_q.push_back(8'h4B);
    wait_tx(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL b2b_wait got=%0d exp=%0d", tx_cnt - tx_rd, exp_q.size()); end
    while (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = tx_log[tx_rd]; tx_rd++;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL b2b_tx got=%h exp=%h", g, e); end
    end
    exp_q.delete();
    idle(10);
    n_cmp++;
    if (tx_cnt != tx_rd) begin n_bad++; $display("FAIL b2b_extra_tx got=%0d exp=0", tx_cnt - tx_rd); tx_rd = tx_cnt; end
    n_cmp++;
    if (rx_in_bus != rib0) begin n_bad++; $display("FAIL b2b_rx_during_bus got=%0d exp=0", rx_in_bus - rib0); end
    n_cmp++;
    if (both_tot != both0 || unstable != un0) begin
      n_bad++;
      $display("FAIL b2b_strobe_rules got=%0d/%0d exp=0/0", both_tot - both0, unstable - un0);
    end
    n_cmp++;
    if (a0 !== 8'h03 || d0 !== 8'h33) begin n_bad++; $display("FAIL b2b_last_write got=%h/%h exp=03/33", a0, d0); end
  endtask

  initial begin
    i_nrst = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_unknown;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
